// File: rtl/fft_pkg.sv
// Shared constants and bank state type for the FFT input loader.
package fft_pkg;

  localparam int FFT_N    = 512;
  localparam int FFT_M    = $clog2(FFT_N);
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    PROC  = 2'd2
  } bank_state_t;

endpackage

// File: rtl/fft_loader_if.sv
// Sample stream, RAM write port and FFT core control bundled for fft_loader.
// Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready never depends on in_valid.
interface fft_loader_if;
  import fft_pkg::*;

  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                in_ready;
  logic                wr_en;
  logic [FFT_M:0]      wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                fft_start;
  logic                fft_bank;
  logic                fft_done;
  bank_state_t         dbg_state0;
  bank_state_t         dbg_state1;
  logic                dbg_fb;

  modport slave (
    input  in_valid, in_data, fft_done,
    output in_ready, wr_en, wr_addr, wr_data, fft_start, fft_bank,
           dbg_state0, dbg_state1, dbg_fb
  );

  modport master (
    output in_valid, in_data, fft_done,
    input  in_ready, wr_en, wr_addr, wr_data, fft_start, fft_bank,
           dbg_state0, dbg_state1, dbg_fb
  );

endinterface

// File: rtl/fft_loader_bitrev.sv
// Bit-reversal of an M-bit index (pure wiring).
module bitrev #(
  parameter int M = 9
) (
  input  logic [M-1:0] i_idx,
  output logic [M-1:0] o_rev
);

  for (genvar i = 0; i < M; i++) begin : g_rev
    assign o_rev[i] = i_idx[M-1-i];
  end

endmodule

// File: rtl/fft_loader.sv
// Ping-pong loader: writes samples at bit-reversed addresses, dispatches full banks to the FFT core.
// Build option OFFSET_BINARY_EN: convert offset-binary input to two's complement by flipping the MSB.
module fft_loader
  import fft_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fft_loader_if.slave  bus
);

  bank_state_t         r_state [2];
  bank_state_t         w_next_state [2];
  logic                r_fb, w_fb_next;
  logic [FFT_M-1:0]    r_cnt, w_cnt_next;
  logic                r_wr_en;
  logic [FFT_M:0]      r_wr_addr;
  logic [SAMPLE_W-1:0] r_wr_data;
  logic                r_fft_start, w_start_next;
  logic                r_fft_bank, w_bank_next;
  logic                w_in_ready, w_accept, w_last;
  logic [FFT_M-1:0]    w_rev;
  logic [SAMPLE_W-1:0] w_sample;

  bitrev #(.M(FFT_M)) u_bitrev (
    .i_idx (r_cnt),
    .o_rev (w_rev)
  );

`ifdef OFFSET_BINARY_EN
  assign w_sample = {~bus.in_data[SAMPLE_W-1], bus.in_data[SAMPLE_W-2:0]};
`else
  assign w_sample = bus.in_data;
`endif

  assign w_in_ready = (r_state[r_fb] == EMPTY);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = w_accept && (r_cnt == FFT_M'(FFT_N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state[0]  <= EMPTY;
      r_state[1]  <= EMPTY;
      r_fb        <= 1'b0;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_fft_start <= 1'b0;
      r_fft_bank  <= 1'b0;
    end else begin
      r_state[0]  <= w_next_state[0];
      r_state[1]  <= w_next_state[1];
      r_fb        <= w_fb_next;
      r_cnt       <= w_cnt_next;
      r_wr_en     <= w_accept;
      if (w_accept) begin
        r_wr_addr <= {r_fb, w_rev};
        r_wr_data <= w_sample;
      end
      r_fft_start <= w_start_next;
      r_fft_bank  <= w_bank_next;
    end
  end

  // The three bank events never target the same bank: the fill bank is EMPTY,
  // the dispatched bank is FULL and the finished bank is PROC.
  always_comb begin
    w_next_state[0] = r_state[0];
    w_next_state[1] = r_state[1];
    w_fb_next       = r_fb;
    w_cnt_next      = r_cnt;
    if (bus.fft_done) begin
      for (int b = 0; b < 2; b++) begin
        if (r_state[b] == PROC) w_next_state[b] = EMPTY;
      end
    end
    if (r_fft_start) w_next_state[r_fft_bank] = PROC;
    if (w_accept) w_cnt_next = r_cnt + 1'b1;
    if (w_last) begin
      w_next_state[r_fb] = FULL;
      w_fb_next          = ~r_fb;
    end
  end

  // Start is registered from the next bank state, so it is high exactly while a FULL bank waits with the core idle.
  always_comb begin
    w_start_next = (w_next_state[0] != PROC) && (w_next_state[1] != PROC) &&
                   ((w_next_state[0] == FULL) || (w_next_state[1] == FULL));
    w_bank_next  = r_fft_bank;
    if (w_start_next) w_bank_next = (w_next_state[1] == FULL);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.fft_start  = r_fft_start;
  assign bus.fft_bank   = r_fft_bank;
  assign bus.dbg_state0 = r_state[0];
  assign bus.dbg_state1 = r_state[1];
  assign bus.dbg_fb     = r_fb;

  a_one_full: assert property (@(posedge clk) disable iff (reset)
    !((r_state[0] == FULL) && (r_state[1] == FULL)));

endmodule

// File: tb/tb_fft_loader.sv
// Bench for fft_loader: cycle-stepped reference model of banks, fill order and dispatch.
module tb_fft_loader;
  import fft_pkg::*;

  localparam int W = SAMPLE_W;
  localparam int M = FFT_M;
  localparam int N = FFT_N;
  localparam int S_EMPTY = 0, S_FULL = 1, S_PROC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_loader_if bif();

  fft_loader dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bif.slave)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_st [2];
  int m_fb, m_cnt, m_bank;
  logic [M+W:0] exp_q [$];
  int start_cnt = 0;
  bit capture = 1'b0;
  logic [M:0]   obs_addr_q [$];
  logic [W-1:0] obs_data_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_bitrev(input int x);
    int r = 0;
    for (int i = 0; i < M; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_sample(input logic [W-1:0] d);
`ifdef OFFSET_BINARY_EN
    return d + W'(1 << (W - 1));
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_st[0] = S_EMPTY;
    m_st[1] = S_EMPTY;
    m_fb = 0;
    m_cnt = 0;
    m_bank = 0;
    exp_q.delete();
  endtask

  // One clock: drive, check outputs at negedge, advance model at posedge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit dn, output bit acc);
    bit exp_ready, exp_start;
    logic [M+W:0] e;
    logic [M:0] a;
    bif.in_valid = v;
    bif.in_data  = d;
    bif.fft_done = dn;
    @(negedge clk);
    exp_ready = (m_st[m_fb] == S_EMPTY);
    exp_start = (m_st[0] != S_PROC) && (m_st[1] != S_PROC) &&
                ((m_st[0] == S_FULL) || (m_st[1] == S_FULL));
    if (exp_start) m_bank = (m_st[1] == S_FULL) ? 1 : 0;
    check_val("in_ready", 32'(bif.in_ready), 32'(exp_ready));
    check_val("fft_start", 32'(bif.fft_start), 32'(exp_start));
    check_val("fft_bank", 32'(bif.fft_bank), 32'(m_bank));
    if (bif.fft_start) start_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("wr_en", 32'(bif.wr_en), 32'd1);
      check_val("wr_addr", 32'(bif.wr_addr), 32'(e[M+W:W]));
      check_val("wr_data", 32'(bif.wr_data), 32'(e[W-1:0]));
    end else begin
      check_val("wr_en_idle", 32'(bif.wr_en), 32'd0);
    end
    if (capture && bif.wr_en) begin
      obs_addr_q.push_back(bif.wr_addr);
      obs_data_q.push_back(bif.wr_data);
    end
    @(posedge clk);
    acc = v && exp_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (dn) begin
        for (int b = 0; b < 2; b++) if (m_st[b] == S_PROC) m_st[b] = S_EMPTY;
      end
      if (exp_start) m_st[m_bank] = S_PROC;
      if (acc) begin
        a = (M+1)'(m_fb * N + ref_bitrev(m_cnt));
        exp_q.push_back({a, ref_sample(d)});
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0;
          m_st[m_fb] = S_FULL;
          m_fb = 1 - m_fb;
        end
      end
    end
    #1;
  endtask

  // driver: offer n random samples back-to-back, bounded wait per sample
  task automatic send_n(input int n);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 2000) begin
        cycle(1'b1, W'($urandom), 1'b0, acc);
        tries++;
      end
      if (!acc) begin
        check_val("accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic idle(input int n, input bit dn);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, dn, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int s0;
    logic [M:0] addr_tab [4];
    addr_tab[0] = 10'h000;
    addr_tab[1] = 10'h100;
    addr_tab[2] = 10'h080;
    addr_tab[3] = 10'h180;

    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    bif.fft_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    idle(2, 1'b0);
    check_val("rst_wr_addr", 32'(bif.wr_addr), 32'd0);
    check_val("rst_wr_data", 32'(bif.wr_data), 32'd0);
    rst = 1'b0;
    idle(4, 1'b0);

    // address order for first four indices
    capture = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(16'h1111 * (i + 1)), 1'b0, acc);
    idle(1, 1'b0);
    capture = 1'b0;
    check_val("addr_count", 32'(obs_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_addr_q.size(); i++) begin
      check_val("addr_order", 32'(obs_addr_q[i]), 32'(addr_tab[i]));
      check_val("data_order", 32'(obs_data_q[i]), 32'(ref_sample(W'(16'h1111 * (i + 1)))));
    end

    // complete frame 0 with core idle
    s0 = start_cnt;
    send_n(N - 4);
    idle(3, 1'b0);
    check_val("frame0_starts", 32'(start_cnt - s0), 32'd1);

    // backpressure: fill bank 1 with no done, then release
    send_n(N);
    repeat (5) cycle(1'b1, W'($urandom), 1'b0, acc);
    check_val("stall_ready", 32'(bif.in_ready), 32'd0);
    s0 = start_cnt;
    idle(1, 1'b1);
    idle(3, 1'b0);
    check_val("bp_starts", 32'(start_cnt - s0), 32'd1);
    check_val("bp_bank", 32'(bif.fft_bank), 32'd1);

    // fill bank 0, release bank 1, then done coinciding with last sample of bank 1
    send_n(N);
    idle(1, 1'b1);
    idle(2, 1'b0);
    send_n(N - 1);
    s0 = start_cnt;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) cycle(1'b1, W'($urandom), 1'b1, acc);
    check_val("simul_accept", 32'(acc), 32'd1);
    idle(5, 1'b0);
    check_val("simul_starts", 32'(start_cnt - s0), 32'd1);
    check_val("simul_bank", 32'(bif.fft_bank), 32'd1);
    idle(1, 1'b1);

    // spurious done while idle
    s0 = start_cnt;
    idle(4, 1'b1);
    idle(2, 1'b0);
    check_val("spurious_starts", 32'(start_cnt - s0), 32'd0);

    // reset mid-frame
    send_n(100);
    rst = 1'b1;
    model_reset();
    idle(2, 1'b0);
    rst = 1'b0;
    s0 = start_cnt;
    idle(3, 1'b0);
    check_val("postrst_starts", 32'(start_cnt - s0), 32'd0);
    send_n(N);
    idle(3, 1'b0);
    check_val("postrst_frame", 32'(start_cnt - s0), 32'd1);
    check_val("postrst_bank", 32'(bif.fft_bank), 32'd0);
    idle(1, 1'b1);

`ifdef OFFSET_BINARY_EN
    obs_data_q.delete();
    capture = 1'b1;
    cycle(1'b1, 16'h8000, 1'b0, acc);
    idle(1, 1'b0);
    capture = 1'b0;
    if (obs_data_q.size() > 0) check_val("offset_bin", 32'(obs_data_q[0]), 32'd0);
    else check_val("offset_bin_write", 32'd0, 32'd1);
`endif

    // randomized traffic with random core completion
    for (int i = 0; i < 3000; i++) begin
      bit v, dn;
      v  = ($urandom_range(0, 3) != 0);
      dn = (((m_st[0] == S_PROC) || (m_st[1] == S_PROC)) && ($urandom_range(0, 15) == 0)) ||
           ($urandom_range(0, 63) == 0);
      cycle(v, W'($urandom), dn, acc);
    end
    idle(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
